// File: rtl/kv_cache_refill.sv
// kv_cache_refill: line refill controller for the 4-way set-associative cache.
// It takes a miss and the LRU victim mask, reads one line from memory into the
// victim way, optionally forwards the critical word, then commits the tag and
// marks the refilled way most-recently-used.
// Optional feature macro: KV_REFILL_CRITICAL_WORD_FIRST_EN
//   defined   -> request starts at the critical word, beats arrive in wrap order
//   undefined -> line-aligned request, beats fill words 0..LINE_WORDS-1 in order
module kv_cache_refill #(
    parameter int unsigned WAYS       = 4,
    parameter int unsigned INDEX_W    = 4,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    localparam int unsigned OFF_W     = $clog2(LINE_WORDS),
    localparam int unsigned TAG_W     = ADDR_W - INDEX_W - OFF_W - 2
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_miss_valid,
    output logic               o_miss_ready,
    input  logic [ADDR_W-1:0]  i_miss_addr,
    input  logic [WAYS-1:0]    i_killmask,
    output logic               o_mem_req_valid,
    input  logic               i_mem_req_ready,
    output logic [ADDR_W-1:0]  o_mem_req_addr,
    input  logic               i_mem_rsp_valid,
    input  logic [DATA_W-1:0]  i_mem_rsp_data,
    output logic [WAYS-1:0]    o_data_we,
    output logic [INDEX_W-1:0] o_data_index,
    output logic [OFF_W-1:0]   o_data_word,
    output logic [DATA_W-1:0]  o_data_wdata,
    output logic [WAYS-1:0]    o_tag_we,
    output logic [INDEX_W-1:0] o_tag_index,
    output logic [TAG_W:0]     o_tag_wdata,
    output logic               o_lru_update,
    output logic [WAYS-1:0]    o_lru_hitway,
    output logic [INDEX_W-1:0] o_lru_index,
    output logic               o_fwd_valid,
    output logic [DATA_W-1:0]  o_fwd_data
);

    typedef enum logic [1:0] {StIdle, StReq, StFill, StCommit} state_e;

    state_e             state;
    logic [OFF_W-1:0]   cnt;
    logic [TAG_W-1:0]   tag_r;
    logic [INDEX_W-1:0] index_r;
    logic [OFF_W-1:0]   crit_r;
    logic [WAYS-1:0]    victim_r;

    logic [TAG_W-1:0]   miss_tag;
    logic [INDEX_W-1:0] miss_index;
    logic [OFF_W-1:0]   miss_crit;
    logic [WAYS-1:0]    victim_norm;
    logic [OFF_W-1:0]   start_word;
    logic [OFF_W-1:0]   beat_word;
    logic [1:0]         unused_byte_off;

    assign miss_tag        = i_miss_addr[ADDR_W-1 -: TAG_W];
    assign miss_index      = i_miss_addr[OFF_W+2 +: INDEX_W];
    assign miss_crit       = i_miss_addr[2 +: OFF_W];
    // Byte offset plays no part in a line refill.
    assign unused_byte_off = i_miss_addr[1:0];

`ifdef KV_REFILL_CRITICAL_WORD_FIRST_EN
    assign start_word = crit_r;
`else
    assign start_word = '0;
`endif

    // Word slot of the current beat; wraps naturally at OFF_W bits.
    assign beat_word = start_word + cnt;

    // Request address is built from captured fields so it stays stable in REQ.
    assign o_mem_req_addr  = {tag_r, index_r, start_word, 2'b00};
    assign o_miss_ready    = (state == StIdle);
    assign o_mem_req_valid = (state == StReq);

    // Victim normalisation: keep the lowest set bit, fall back to way 0 when empty.
    always_comb begin
        victim_norm = i_killmask & (~i_killmask + WAYS'(1));
        if (i_killmask == '0) begin
            victim_norm = WAYS'(1);
        end
    end

    // Refill FSM with registered array, forward and LRU outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state        <= StIdle;
            cnt          <= '0;
            tag_r        <= '0;
            index_r      <= '0;
            crit_r       <= '0;
            victim_r     <= '0;
            o_data_we    <= '0;
            o_data_index <= '0;
            o_data_word  <= '0;
            o_data_wdata <= '0;
            o_tag_we     <= '0;
            o_tag_index  <= '0;
            o_tag_wdata  <= '0;
            o_lru_update <= 1'b0;
            o_lru_hitway <= '0;
            o_lru_index  <= '0;
            o_fwd_valid  <= 1'b0;
            o_fwd_data   <= '0;
        end else begin
            // Write enables and pulses last exactly one cycle.
            o_data_we    <= '0;
            o_tag_we     <= '0;
            o_lru_update <= 1'b0;
            o_fwd_valid  <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (i_miss_valid) begin
                        tag_r       <= miss_tag;
                        index_r     <= miss_index;
                        crit_r      <= miss_crit;
                        victim_r    <= victim_norm;
                        cnt         <= '0;
                        // Invalidate the victim first so a half-filled line never hits.
                        o_tag_we    <= victim_norm;
                        o_tag_index <= miss_index;
                        o_tag_wdata <= {1'b0, miss_tag};
                        state       <= StReq;
                    end
                end
                StReq: begin
                    if (i_mem_req_ready) begin
                        state <= StFill;
                    end
                end
                StFill: begin
                    if (i_mem_rsp_valid) begin
                        o_data_we    <= victim_r;
                        o_data_index <= index_r;
                        o_data_word  <= beat_word;
                        o_data_wdata <= i_mem_rsp_data;
                        if (beat_word == crit_r) begin
                            o_fwd_valid <= 1'b1;
                            o_fwd_data  <= i_mem_rsp_data;
                        end
                        cnt <= cnt + OFF_W'(1);
                        if (cnt == OFF_W'(LINE_WORDS - 1)) begin
                            // Commit outputs land together with the last data write.
                            o_tag_we     <= victim_r;
                            o_tag_index  <= index_r;
                            o_tag_wdata  <= {1'b1, tag_r};
                            o_lru_update <= 1'b1;
                            o_lru_hitway <= victim_r;
                            o_lru_index  <= index_r;
                            state        <= StCommit;
                        end
                    end
                end
                StCommit: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kv_cache_refill.sv
// Bench for kv_cache_refill: a per-cycle expectation timeline is derived from the
// miss/beat timing the bench itself schedules, and every cycle is compared.
module tb_kv_cache_refill;

    localparam int MAXC = 4096;

    logic        clk = 1'b0;
    logic        rstn;
    logic        miss_valid;
    logic        miss_ready;
    logic [31:0] miss_addr;
    logic [3:0]  killmask;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [3:0]  data_we;
    logic [3:0]  data_index;
    logic [1:0]  data_word;
    logic [31:0] data_wdata;
    logic [3:0]  tag_we;
    logic [3:0]  tag_index;
    logic [24:0] tag_wdata;
    logic        lru_update;
    logic [3:0]  lru_hitway;
    logic [3:0]  lru_index;
    logic        fwd_valid;
    logic [31:0] fwd_data;

    kv_cache_refill dut (
        .i_clk           (clk),
        .i_rstn          (rstn),
        .i_miss_valid    (miss_valid),
        .o_miss_ready    (miss_ready),
        .i_miss_addr     (miss_addr),
        .i_killmask      (killmask),
        .o_mem_req_valid (req_valid),
        .i_mem_req_ready (req_ready),
        .o_mem_req_addr  (req_addr),
        .i_mem_rsp_valid (rsp_valid),
        .i_mem_rsp_data  (rsp_data),
        .o_data_we       (data_we),
        .o_data_index    (data_index),
        .o_data_word     (data_word),
        .o_data_wdata    (data_wdata),
        .o_tag_we        (tag_we),
        .o_tag_index     (tag_index),
        .o_tag_wdata     (tag_wdata),
        .o_lru_update    (lru_update),
        .o_lru_hitway    (lru_hitway),
        .o_lru_index     (lru_index),
        .o_fwd_valid     (fwd_valid),
        .o_fwd_data      (fwd_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;
    bit run     = 1'b0;

    // Expected outputs per cycle.
    logic        e_mready   [MAXC];
    logic        e_rvalid   [MAXC];
    logic [31:0] e_raddr    [MAXC];
    logic [3:0]  e_data_we  [MAXC];
    logic [3:0]  e_data_idx [MAXC];
    logic [1:0]  e_data_word[MAXC];
    logic [31:0] e_data_wd  [MAXC];
    logic [3:0]  e_tag_we   [MAXC];
    logic [3:0]  e_tag_idx  [MAXC];
    logic [24:0] e_tag_wd   [MAXC];
    logic        e_lru_upd  [MAXC];
    logic [3:0]  e_lru_way  [MAXC];
    logic [3:0]  e_lru_idx  [MAXC];
    logic        e_fwd_v    [MAXC];
    logic [31:0] e_fwd_d    [MAXC];

    // Observations used by the hand-computed checks.
    int          n_wr  = 0;
    int          n_tagv = 0;
    logic [3:0]  last_wr_way;
    logic [24:0] last_tagv;
    logic [3:0]  inv_way;
    logic [3:0]  inv_idx;
    logic [31:0] fwd_last;
    logic [3:0]  lru_way_last;
    logic [3:0]  lru_idx_last;
    logic [31:0] raddr_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] norm_victim(input logic [3:0] k);
        for (int i = 0; i < 4; i++) if (k[i]) return 4'(1 << i);
        return 4'b0001;
    endfunction

    // Per-cycle compare against the expectation timeline.
    always @(negedge clk) begin
        if (run) begin
            check("miss_ready", 64'(miss_ready), 64'(e_mready[cyc]));
            check("req_valid", 64'(req_valid), 64'(e_rvalid[cyc]));
            if (e_rvalid[cyc]) check("req_addr", 64'(req_addr), 64'(e_raddr[cyc]));
            check("data_we", 64'(data_we), 64'(e_data_we[cyc]));
            if (e_data_we[cyc] != 4'b0) begin
                check("data_index", 64'(data_index), 64'(e_data_idx[cyc]));
                check("data_word", 64'(data_word), 64'(e_data_word[cyc]));
                check("data_wdata", 64'(data_wdata), 64'(e_data_wd[cyc]));
            end
            check("tag_we", 64'(tag_we), 64'(e_tag_we[cyc]));
            if (e_tag_we[cyc] != 4'b0) begin
                check("tag_index", 64'(tag_index), 64'(e_tag_idx[cyc]));
                check("tag_wdata", 64'(tag_wdata), 64'(e_tag_wd[cyc]));
            end
            check("lru_update", 64'(lru_update), 64'(e_lru_upd[cyc]));
            if (e_lru_upd[cyc]) begin
                check("lru_hitway", 64'(lru_hitway), 64'(e_lru_way[cyc]));
                check("lru_index", 64'(lru_index), 64'(e_lru_idx[cyc]));
            end
            check("fwd_valid", 64'(fwd_valid), 64'(e_fwd_v[cyc]));
            if (e_fwd_v[cyc]) check("fwd_data", 64'(fwd_data), 64'(e_fwd_d[cyc]));
        end
    end

    // Event recorder.
    always @(negedge clk) begin
        if (run) begin
            if (data_we != 4'b0) begin
                n_wr++;
                last_wr_way = data_we;
            end
            if (tag_we != 4'b0 && tag_wdata[24]) begin
                n_tagv++;
                last_tagv = tag_wdata;
            end
            if (tag_we != 4'b0 && !tag_wdata[24]) begin
                inv_way = tag_we;
                inv_idx = tag_index;
            end
            if (fwd_valid) fwd_last = fwd_data;
            if (lru_update) begin
                lru_way_last = lru_hitway;
                lru_idx_last = lru_index;
            end
            if (req_valid) raddr_last = req_addr;
        end
    end

    // One miss: schedule request/beat timing, derive expectations, then drive it.
    // abort_after < 4 pulls reset one cycle after that many beats have been written.
    task automatic run_miss(input logic [31:0] addr, input logic [3:0] kill, input int req_delay,
                            input int g0, input int g1, input int g2, input int g3,
                            input bit stray, input bit hold_busy, input int abort_after,
                            input logic [31:0] dbase);
        int          t, r, l, x, last, nb, bi;
        int          b[4];
        int          g[4];
        logic [31:0] d[4];
        logic [23:0] tg;
        logic [3:0]  ix, v;
        logic [1:0]  cr, st, w;
        logic [31:0] raddr;
        bit          is_beat;
        g  = '{g0, g1, g2, g3};
        t  = cyc;
        tg = addr[31:8];
        ix = addr[7:4];
        cr = addr[3:2];
        v  = norm_victim(kill);
`ifdef KV_REFILL_CRITICAL_WORD_FIRST_EN
        st = cr;
`else
        st = 2'd0;
`endif
        raddr = {tg, ix, st, 2'b00};
        r     = t + 1 + req_delay;
        b[0]  = r + 1 + g[0];
        for (int i = 1; i < 4; i++) b[i] = b[i-1] + 1 + g[i];
        l     = b[3];
        nb    = (abort_after < 4) ? abort_after : 4;
        x     = (nb > 0) ? b[nb-1] + 1 : r + 1;
        last  = (abort_after < 4) ? x : l + 1;
        if (last + 2 >= MAXC) begin
            $display("FAIL cycle_budget: got %0d, expected below %0d", last + 2, MAXC);
            $fatal(1);
        end
        for (int i = 0; i < 4; i++) d[i] = (dbase != 0) ? dbase + 32'(i) : $urandom;

        e_tag_we[t+1]  = v;
        e_tag_idx[t+1] = ix;
        e_tag_wd[t+1]  = {1'b0, tg};
        for (int c = t + 1; c <= r; c++) begin
            e_rvalid[c] = 1'b1;
            e_raddr[c]  = raddr;
        end
        for (int c = t + 1; c <= last; c++) e_mready[c] = 1'b0;
        for (int i = 0; i < nb; i++) begin
            w = st + 2'(i);
            e_data_we[b[i]+1]   = v;
            e_data_idx[b[i]+1]  = ix;
            e_data_word[b[i]+1] = w;
            e_data_wd[b[i]+1]   = d[i];
            if (w == cr) begin
                e_fwd_v[b[i]+1] = 1'b1;
                e_fwd_d[b[i]+1] = d[i];
            end
        end
        if (abort_after >= 4) begin
            e_tag_we[l+1]  = v;
            e_tag_idx[l+1] = ix;
            e_tag_wd[l+1]  = {1'b1, tg};
            e_lru_upd[l+1] = 1'b1;
            e_lru_way[l+1] = v;
            e_lru_idx[l+1] = ix;
        end

        miss_valid = 1'b1;
        miss_addr  = addr;
        killmask   = kill;
        req_ready  = 1'b0;
        rsp_valid  = stray;
        rsp_data   = $urandom;
        tick();
        for (int c = t + 1; c <= last; c++) begin
            is_beat = 1'b0;
            bi      = 0;
            for (int i = 0; i < nb; i++) begin
                if (b[i] == c) begin
                    is_beat = 1'b1;
                    bi      = i;
                end
            end
            miss_valid = hold_busy && (c <= l + 1);
            if (hold_busy) begin
                miss_addr = addr ^ 32'h0000_5A50;
                killmask  = ~kill;
            end else begin
                miss_addr = $urandom;
            end
            req_ready = (c == r) ? 1'b1 : ((c < r) ? 1'b0 : 1'($urandom_range(0, 1)));
            rsp_valid = is_beat || (stray && c == t + 1 && r > t + 1);
            rsp_data  = is_beat ? d[bi] : $urandom;
            rstn      = !(abort_after < 4 && c == x);
            tick();
        end
        miss_valid = 1'b0;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rstn       = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_miss_ready"}, 64'(miss_ready), 64'(1));
        check({tag, "_req_valid"}, 64'(req_valid), 64'(0));
        check({tag, "_req_addr"}, 64'(req_addr), 64'(0));
        check({tag, "_data_we"}, 64'(data_we), 64'(0));
        check({tag, "_data_fields"}, {data_index, data_word, data_wdata}, 64'(0));
        check({tag, "_tag_we"}, 64'(tag_we), 64'(0));
        check({tag, "_tag_fields"}, {tag_index, tag_wdata}, 64'(0));
        check({tag, "_lru"}, {lru_update, lru_hitway, lru_index}, 64'(0));
        check({tag, "_fwd"}, {fwd_valid, fwd_data}, 64'(0));
    endtask

    initial begin
        int n0, tv0;
        for (int c = 0; c < MAXC; c++) begin
            e_mready[c]    = 1'b1;
            e_rvalid[c]    = 1'b0;
            e_raddr[c]     = '0;
            e_data_we[c]   = '0;
            e_data_idx[c]  = '0;
            e_data_word[c] = '0;
            e_data_wd[c]   = '0;
            e_tag_we[c]    = '0;
            e_tag_idx[c]   = '0;
            e_tag_wd[c]    = '0;
            e_lru_upd[c]   = 1'b0;
            e_lru_way[c]   = '0;
            e_lru_idx[c]   = '0;
            e_fwd_v[c]     = 1'b0;
            e_fwd_d[c]     = '0;
        end
        rstn       = 1'b0;
        miss_valid = 1'b0;
        miss_addr  = '0;
        killmask   = '0;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_data   = '0;
        repeat (3) tick();
        check_all_zero("reset");
        rstn = 1'b1;
        run  = 1'b1;

        // Basic fill, word offset 1.
        n0  = n_wr;
        tv0 = n_tagv;
        run_miss(32'h0000_1234, 4'b0100, 0, 0, 0, 0, 0, 1'b0, 1'b0, 4, 32'hA0);
        check("t1_inv_way", 64'(inv_way), 64'(4'b0100));
        check("t1_inv_idx", 64'(inv_idx), 64'(3));
        check("t1_writes", 64'(n_wr - n0), 64'(4));
        check("t1_wr_way", 64'(last_wr_way), 64'(4'b0100));
        check("t1_tag_valid_writes", 64'(n_tagv - tv0), 64'(1));
        check("t1_tag_wdata", 64'(last_tagv), 64'(25'h100_0012));
        check("t1_lru_way", 64'(lru_way_last), 64'(4'b0100));
        check("t1_lru_idx", 64'(lru_idx_last), 64'(3));
`ifdef KV_REFILL_CRITICAL_WORD_FIRST_EN
        check("t1_req_addr", 64'(raddr_last), 64'(32'h0000_1234));
        check("t1_fwd", 64'(fwd_last), 64'(32'hA0));
`else
        check("t1_req_addr", 64'(raddr_last), 64'(32'h0000_1230));
        check("t1_fwd", 64'(fwd_last), 64'(32'hA1));
`endif

        // Critical word at offset 2, with a request wait and one beat gap.
        run_miss(32'h0ABC_DE48, 4'b1000, 1, 0, 1, 0, 0, 1'b0, 1'b0, 4, 32'hB0);
`ifdef KV_REFILL_CRITICAL_WORD_FIRST_EN
        check("t2_req_addr", 64'(raddr_last), 64'(32'h0ABC_DE48));
        check("t2_fwd", 64'(fwd_last), 64'(32'hB0));
`else
        check("t2_req_addr", 64'(raddr_last), 64'(32'h0ABC_DE40));
        check("t2_fwd", 64'(fwd_last), 64'(32'hB2));
`endif

        // Backpressure: 5-cycle request stall, 2-cycle beat gaps, stray beat in REQ.
        n0 = n_wr;
        run_miss(32'h7654_3210, 4'b0001, 5, 2, 2, 2, 2, 1'b1, 1'b0, 4, 32'h0);
        check("t3_writes", 64'(n_wr - n0), 64'(4));

        // Victim normalisation.
        run_miss(32'h0000_0F00, 4'b0110, 0, 0, 0, 0, 0, 1'b0, 1'b0, 4, 32'h0);
        check("t4_multi_hot_way", 64'(last_wr_way), 64'(4'b0010));
        run_miss(32'h0000_0E00, 4'b0000, 0, 0, 0, 0, 0, 1'b0, 1'b0, 4, 32'h0);
        check("t4_zero_mask_way", 64'(last_wr_way), 64'(4'b0001));

        // Reset after two beats: line abandoned, no valid tag written.
        tv0 = n_tagv;
        run_miss(32'h1357_9BD0, 4'b0010, 0, 0, 0, 0, 0, 1'b0, 1'b0, 2, 32'h0);
        check_all_zero("t5_abort");
        check("t5_no_tag_valid", 64'(n_tagv - tv0), 64'(0));
        run_miss(32'h1357_9BD0, 4'b0010, 0, 0, 0, 0, 0, 1'b0, 1'b0, 4, 32'h0);
        check("t5_recover_tag_valid", 64'(n_tagv - tv0), 64'(1));

        // Busy rejection: a second miss held high during the whole refill.
        run_miss(32'h2468_ACE4, 4'b1000, 2, 1, 0, 1, 0, 1'b0, 1'b1, 4, 32'h0);
        check("t6_tag_wdata", 64'(last_tagv), 64'(25'h124_68AC));
        check("t6_lru_idx", 64'(lru_idx_last), 64'(4'hE));

        // Randomised misses with idle gaps and stray beats.
        for (int k = 0; k < 40; k++) begin
            run_miss($urandom, 4'($urandom), $urandom_range(0, 3),
                     $urandom_range(0, 2), $urandom_range(0, 2),
                     $urandom_range(0, 2), $urandom_range(0, 2),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4, 32'h0);
            repeat ($urandom_range(0, 2)) begin
                rsp_valid = 1'($urandom_range(0, 1));
                rsp_data  = $urandom;
                tick();
            end
            rsp_valid = 1'b0;
        end

        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
